// File: rtl/scan_chain_driver_if.sv
// Chain-side signals between the scan-chain driver and the chain of designs.
// Latency: none, wires only.
// Backpressure: none; the chain follows the driver's scan clock.
interface scan_chain_driver_if;
    logic scan_clk_out;
    logic scan_data_out;
    logic scan_select;
    logic scan_latch_en;
    logic scan_clk_in;
    logic scan_data_in;

    modport master (
        output scan_clk_out,
        output scan_data_out,
        output scan_select,
        output scan_latch_en,
        input  scan_clk_in,
        input  scan_data_in
    );

    modport slave (
        input  scan_clk_out,
        input  scan_data_out,
        input  scan_select,
        input  scan_latch_en,
        output scan_clk_in,
        output scan_data_in
    );
endinterface

// File: rtl/scan_chain_driver.sv
// Refreshes one selected design on the scan chain: shift inputs in, latch, load outputs, shift back, capture.
// Latency: one refresh is 1 + 2*(sck_div+1)*((NUM_DESIGNS+1)*NUM_IOS+1) + 5*(ws_cfg+1) + 2 cycles, done one cycle after CAP.
// Backpressure: requests are only taken in IDLE; start/enable are ignored while busy or while active_select is invalid.
module scan_chain_driver #(
    parameter int NUM_DESIGNS = 8,
    parameter int NUM_IOS     = 8,
    parameter int SEL_W       = 9,
    parameter int WS_W        = 8,
    parameter int DIV_W       = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                start,
    input  logic [SEL_W-1:0]    active_select,
    input  logic [NUM_IOS-1:0]  inputs,
    input  logic [WS_W-1:0]     ws_cfg,
    input  logic [DIV_W-1:0]    sck_div,
    output logic [NUM_IOS-1:0]  outputs,
    output logic                busy,
    output logic                done,
    output logic                chain_err,
    output logic                bad_sel,
    scan_chain_driver_if.master chain
);

    // Largest edge count of a refresh is (NUM_DESIGNS+1)*NUM_IOS+1, so counters never wrap.
    localparam int MAX_BITS = (NUM_DESIGNS + 1) * NUM_IOS + 1;
    localparam int CW       = $clog2(MAX_BITS + 1);

    typedef enum logic [3:0] {
        IDLE, IN_LOAD, IN_SHIFT, IN_LATCH_WAIT, IN_LATCH,
        OUT_PRE, OUT_LOAD, OUT_POST, OUT_CLR, OUT_SHIFT,
        CAP_WAIT, CAP
    } state_t;

    state_t             state;
    logic [NUM_IOS-1:0] in_sr;
    logic [SEL_W-1:0]   sel_q;
    logic [WS_W-1:0]    ws_q;
    logic [DIV_W-1:0]   div_q;
    logic [CW-1:0]      in_bits_q;
    logic [CW-1:0]      out_bits_q;
    logic [CW-1:0]      bit_cnt;
    logic [CW-1:0]      bit_nxt;
    logic [CW-1:0]      bit_goal;
    logic [CW-1:0]      iss_cnt;
    logic [CW-1:0]      ret_cnt;
    logic [DIV_W-1:0]   ph_cnt;
    logic               ph_hi;
    logic [WS_W-1:0]    wait_cnt;
    logic               ph_last;
    logic               wait_last;

    logic               sck_s1, sck_s2, sck_s3;
    logic               sd_s1, sd_s2, sd_s3;
    logic               sck_rise;
    logic [NUM_IOS-1:0] ret_sr;

    assign bad_sel   = (int'(active_select) >= NUM_DESIGNS);
    assign ph_last   = (ph_cnt == div_q);
    assign wait_last = (wait_cnt == ws_q);
    assign bit_nxt   = bit_cnt + CW'(1);
    assign sck_rise  = sck_s2 & ~sck_s3;

    // Number of scan bits the current shifting state must issue.
    always_comb begin
        bit_goal = out_bits_q;
        if (state == IN_SHIFT) begin
            bit_goal = in_bits_q;
        end else if (state == OUT_LOAD) begin
            bit_goal = CW'(1);
        end
    end

    // Feedback synchronizers; returned data changes with the returned clock edge, so the
    // bit shifted in is the data sample taken alongside the last low clock sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            sck_s3 <= 1'b0;
            sd_s1  <= 1'b0;
            sd_s2  <= 1'b0;
            sd_s3  <= 1'b0;
            ret_sr <= '0;
        end else begin
            sck_s1 <= chain.scan_clk_in;
            sck_s2 <= sck_s1;
            sck_s3 <= sck_s2;
            sd_s1  <= chain.scan_data_in;
            sd_s2  <= sd_s1;
            sd_s3  <= sd_s2;
            if (sck_rise) begin
                ret_sr <= {ret_sr[NUM_IOS-2:0], sd_s3};
            end
        end
    end

    // Refresh sequencer with registered chain controls and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            in_sr               <= '0;
            sel_q               <= '0;
            ws_q                <= '0;
            div_q               <= '0;
            in_bits_q           <= '0;
            out_bits_q          <= '0;
            bit_cnt             <= '0;
            iss_cnt             <= '0;
            ret_cnt             <= '0;
            ph_cnt              <= '0;
            ph_hi               <= 1'b0;
            wait_cnt            <= '0;
            outputs             <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            chain_err           <= 1'b0;
            chain.scan_clk_out  <= 1'b0;
            chain.scan_data_out <= 1'b0;
            chain.scan_select   <= 1'b0;
            chain.scan_latch_en <= 1'b0;
        end else begin
            done <= 1'b0;
            if (sck_rise && (state != IDLE) && (ret_cnt != '1)) begin
                ret_cnt <= ret_cnt + CW'(1);
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        chain_err <= 1'b0;
                    end
                    // Operands are captured on the request edge so the validated select is the one used.
                    if ((start || enable) && !bad_sel) begin
                        state   <= IN_LOAD;
                        busy    <= 1'b1;
                        in_sr   <= inputs;
                        sel_q   <= active_select;
                        ws_q    <= ws_cfg;
                        div_q   <= sck_div;
                        iss_cnt <= '0;
                        ret_cnt <= '0;
                    end
                end

                IN_LOAD: begin
                    in_bits_q           <= CW'((int'(sel_q) + 1) * NUM_IOS);
                    out_bits_q          <= CW'((NUM_DESIGNS - int'(sel_q)) * NUM_IOS);
                    chain.scan_clk_out  <= 1'b0;
                    chain.scan_data_out <= in_sr[NUM_IOS-1];
                    in_sr               <= in_sr << 1;
                    ph_cnt              <= '0;
                    ph_hi               <= 1'b0;
                    bit_cnt             <= '0;
                    state               <= IN_SHIFT;
                end

                IN_SHIFT, OUT_LOAD, OUT_SHIFT: begin
                    if (!ph_last) begin
                        ph_cnt <= ph_cnt + DIV_W'(1);
                    end else begin
                        ph_cnt <= '0;
                        if (!ph_hi) begin
                            ph_hi              <= 1'b1;
                            chain.scan_clk_out <= 1'b1;
                            iss_cnt            <= iss_cnt + CW'(1);
                        end else begin
                            ph_hi              <= 1'b0;
                            chain.scan_clk_out <= 1'b0;
                            bit_cnt            <= bit_nxt;
                            if (bit_nxt == bit_goal) begin
                                wait_cnt            <= '0;
                                chain.scan_data_out <= 1'b0;
                                if (state == IN_SHIFT) begin
                                    state <= IN_LATCH_WAIT;
                                end else if (state == OUT_LOAD) begin
                                    state <= OUT_POST;
                                end else begin
                                    state <= CAP_WAIT;
                                end
                            end else begin
                                // Zero fill behind the payload pushes it down to the selected design.
                                chain.scan_data_out <= (state == IN_SHIFT) ? in_sr[NUM_IOS-1] : 1'b0;
                                in_sr               <= in_sr << 1;
                            end
                        end
                    end
                end

                IN_LATCH_WAIT, OUT_PRE, OUT_POST, OUT_CLR, CAP_WAIT: begin
                    if (!wait_last) begin
                        wait_cnt <= wait_cnt + WS_W'(1);
                    end else begin
                        wait_cnt <= '0;
                        ph_cnt   <= '0;
                        ph_hi    <= 1'b0;
                        bit_cnt  <= '0;
                        if (state == IN_LATCH_WAIT) begin
                            chain.scan_latch_en <= 1'b1;
                            state               <= IN_LATCH;
                        end else if (state == OUT_PRE) begin
                            chain.scan_data_out <= 1'b0;
                            state               <= OUT_LOAD;
                        end else if (state == OUT_POST) begin
                            chain.scan_select <= 1'b0;
                            state             <= OUT_CLR;
                        end else if (state == OUT_CLR) begin
                            chain.scan_data_out <= 1'b0;
                            state               <= OUT_SHIFT;
                        end else begin
                            state <= CAP;
                        end
                    end
                end

                IN_LATCH: begin
                    chain.scan_latch_en <= 1'b0;
                    chain.scan_select   <= 1'b1;
                    wait_cnt            <= '0;
                    state               <= OUT_PRE;
                end

                CAP: begin
                    outputs <= ret_sr;
                    if (iss_cnt != ret_cnt) begin
                        chain_err <= 1'b1;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/scan_chain_driver.md
Name: scan_chain_driver

Overview:
- Parametrised successor to the internal scan-chain driver of the scan controller.
- Serially refreshes one selected tiny design per cycle of operation: shifts NUM_IOS input bits into it, latches them, loads every design's outputs, shifts them back, and captures the selected design's NUM_IOS outputs.
- New versus the current driver: programmable scan-clock half-period, single-shot or continuous mode with start/done handshake, fully single-clock feedback sampling, chain-integrity check and invalid-select rejection.
- Sits between the driver_sel mux and the chain of designs.

Parameters:
- NUM_DESIGNS, 8, designs on the chain.
- NUM_IOS, 8, scan bits per design.
- SEL_W, 9, width of active_select.
- WS_W, 8, width of wait-state config.
- DIV_W, 4, width of scan-clock divider.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  continuous mode: start a new refresh whenever IDLE.
- start  in  1  single-shot request, sampled in IDLE only.
- active_select  in  SEL_W  design index to drive/capture.
- inputs  in  NUM_IOS  values shifted into the selected design.
- ws_cfg  in  WS_W  wait cycles per wait state.
- sck_div  in  DIV_W  scan clock phase length minus one.
- outputs  out  NUM_IOS  captured outputs of selected design.
- busy  out  1  high from IN_LOAD through CAP.
- done  out  1  one-cycle pulse in cycle after CAP.
- chain_err  out  1  sticky; set on returned-edge mismatch.
- bad_sel  out  1  high while active_select >= NUM_DESIGNS.
- scan_clk_out, scan_data_out, scan_select, scan_latch_en  out  1  chain controls, all registered.
- scan_clk_in, scan_data_in  in  1  chain feedback, asynchronous.

Behaviour:
- Reset values:
  - all outputs 0, state IDLE, counters 0.
  - Asserting reset mid-refresh aborts at the next edge; no latch pulse is issued afterwards.
- Reserved-bit/invalid select: bad_sel = (active_select >= NUM_DESIGNS), combinational. A request while bad_sel=1 is ignored: stays IDLE, busy=0, no done.
- Request rule: in IDLE, (start | enable) & ~bad_sel -> IN_LOAD next cycle.
- IN_LOAD (1 cycle): latch inputs, active_select, ws_cfg and sck_div; these are held for the whole refresh.
- Bit timing:
  - each scan bit = LO phase of (sck_div+1) cycles with scan_clk_out=0, then HI phase of (sck_div+1) cycles with scan_clk_out=1.
  - scan_data_out updates on entry to LO.
- IN_SHIFT:
  - shift (sel+1)*NUM_IOS bits, MSB of the input shift register first, zero-filled behind.
  - The first NUM_IOS bits sent are inputs[NUM_IOS-1:0] MSB-first; the remaining bits are 0 and push the payload down to design sel.
  - Then -> IN_LATCH_WAIT.
- Wait states:
  - IN_LATCH_WAIT, OUT_PRE, OUT_POST, OUT_CLR and CAP_WAIT each last ws_cfg+1 cycles.
  - The wait counter clears on entry to each wait state.
- IN_LATCH: 1 cycle, scan_latch_en=1.
- Output load sequence:
  - OUT_PRE: scan_select=1.
  - OUT_LOAD: one full scan bit (LO then HI phase) with scan_select=1.
  - OUT_POST: scan_select=1.
  - OUT_CLR: scan_select=0.
- OUT_SHIFT: (NUM_DESIGNS-sel)*NUM_IOS bits, scan_data_out=0 -> CAP_WAIT -> CAP (1 cycle) -> IDLE.
- Feedback path:
  - scan_clk_in and scan_data_in each pass through a 2-flop synchronizer.
  - A rising edge of synchronized clk shifts synchronized data into an NUM_IOS-bit return register at the LSB.
  - CAP copies the return register to outputs.
- Integrity check:
  - Count issued scan-clock rising edges and returned edges over the refresh, including edges that return during CAP_WAIT.
  - At CAP, if the counts differ, set chain_err.
  - chain_err clears only on reset or on start=1 in IDLE.
- Counter widths: bit counters are sized for (NUM_DESIGNS+1)*NUM_IOS+1 with no wrap.
- Constraint: sck_div >= 2 is required for reliable feedback sampling; sck_div < 2 is still executed, but chain_err may set.
- Simultaneous start and enable are treated as one request. enable held high gives back-to-back refreshes with exactly one IDLE cycle between them.

Test Plan:
- NUM_DESIGNS=4, NUM_IOS=8, loopback chain model, sel=2, inputs=0xA5, sck_div=2, ws_cfg=3, start pulse -> model design 2 holds 0xA5 after the latch pulse; done pulses once; chain_err=0.
- Same setup, model outputs of design 2 = 0x3C -> outputs=0x3C from the cycle after CAP.
- enable held high for 3 refreshes -> 3 done pulses, each separated by exactly one IDLE cycle; inputs changed mid-refresh do not take effect until the next IN_LOAD.
- active_select=4 with NUM_DESIGNS=4, start pulse -> bad_sel=1, busy stays 0, no done pulse.
- Model drops one returned clock edge -> chain_err=1 after CAP and stays set; next start pulse clears it.
- reset asserted during IN_SHIFT -> next cycle all outputs 0, state IDLE, no scan_latch_en pulse.
